// File: rtl/inst_fetch_queue.sv
// Instruction-fetch queue: issues synchronous ROM reads for each enabled pc,
// captures the returned word with its address and buffers up to DEPTH fetched
// instructions for decode behind a valid/ready handshake. A conservative stall
// back to the PC stage guarantees no returning word ever finds the queue full.
module inst_fetch_queue #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    // PC stage
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    output logic              fetch_stall,
    // Instruction ROM, read data valid one cycle after rom_ce
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    // Pipeline control
    input  logic              flush,
    // Decode stage
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    // Entry storage, not reset: the head outputs are masked while the queue is empty.
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [DATA_W-1:0] mem_inst_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [OCC_W-1:0]  occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // Stall and issue decisions: occupancy uses registered state only, so a pop this
    // cycle never relieves the stall and id_ready has no path to fetch_stall.
    always_comb begin
        occupancy   = OCC_W'(count_q) + OCC_W'(inflight_q);
        fetch_stall = (occupancy >= OCC_W'(DEPTH));
        issue       = ce & ~fetch_stall & ~flush;
        rom_ce      = issue;
        rom_addr    = pc;
    end

    // Head outputs and queue events; flush overrides both push and pop.
    always_comb begin
        id_valid = (count_q != '0);
        id_pc    = '0;
        id_inst  = '0;
        if (id_valid) begin
            id_pc   = mem_pc_q[rd_ptr_q];
            id_inst = mem_inst_q[rd_ptr_q];
        end
        push = inflight_q & ~flush;
        pop  = id_valid & id_ready & ~flush;
    end

    // Next-state for pointers, occupancy count and the in-flight tracker.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        if (issue) begin
            inflight_pc_d = pc;
        end

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset wins over flush, push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Capture the returning ROM word with the address it was fetched from.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
            mem_inst_q[wr_ptr_q] <= rom_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              fetch_stall;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;

    inst_fetch_queue #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ce         (ce),
        .fetch_stall(fetch_stall),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_inst    (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + DATA_W'(a);
    endfunction

    // Synchronous ROM; garbage when not read so stray captures show up.
    always @(posedge clk) begin
        rom_data <= rom_ce ? rom_word(rom_addr) : 32'hDEAD_BEEF;
    end

    // Reference model state
    entry_t            mq[$];
    logic              m_inflight;
    logic [ADDR_W-1:0] m_inflight_pc;
    logic [ADDR_W-1:0] pc_r;
    logic              exp_issue;

    int total_cnt;
    int pass_cnt;
    int fail_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and compare outputs with the model.
    task automatic drive(input logic ce_v, input logic rdy_v, input logic fl_v, input logic rst_v);
        logic             m_stall;
        logic [ADDR_W-1:0] e_pc;
        logic [DATA_W-1:0] e_inst;
        @(negedge clk);
        ce       = ce_v;
        id_ready = rdy_v;
        flush    = fl_v;
        rst      = rst_v;
        pc       = pc_r;
        #1;
        m_stall   = (mq.size() + int'(m_inflight)) >= DEPTH;
        exp_issue = ce_v && !m_stall && !fl_v;
        e_pc      = (mq.size() != 0) ? mq[0].pc : '0;
        e_inst    = (mq.size() != 0) ? mq[0].inst : '0;
        check("fetch_stall", 64'(fetch_stall), 64'(m_stall));
        check("rom_ce", 64'(rom_ce), 64'(exp_issue));
        check("rom_addr", 64'(rom_addr), 64'(pc_r));
        check("id_valid", 64'(id_valid), 64'(mq.size() != 0));
        check("id_pc", 64'(id_pc), 64'(e_pc));
        check("id_inst", 64'(id_inst), 64'(e_inst));
    endtask

    // Advance the model across the rising edge using the inputs set by drive().
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_inflight    = 1'b0;
            m_inflight_pc = '0;
        end else if (flush) begin
            mq.delete();
            m_inflight = 1'b0;
        end else begin
            if (mq.size() != 0 && id_ready) void'(mq.pop_front());
            if (m_inflight) begin
                entry_t e;
                e.pc   = m_inflight_pc;
                e.inst = rom_word(m_inflight_pc);
                mq.push_back(e);
            end
            m_inflight = exp_issue;
            if (exp_issue) begin
                m_inflight_pc = pc_r;
                pc_r          = pc_r + ADDR_W'(1);
            end
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] flush_pc;
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        mq.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        pc_r          = '0;
        exp_issue     = 1'b0;
        rst = 1'b1; ce = 1'b0; flush = 1'b0; id_ready = 1'b0; pc = '0;

        // Reset for two cycles, then stream with decode always ready.
        repeat (2) begin drive(0, 0, 0, 1); tick(); end
        drive(1, 1, 0, 0);
        check("reset_valid", 64'(id_valid), 64'd0);
        check("reset_stall", 64'(fetch_stall), 64'd0);
        check("reset_rom_ce", 64'(rom_ce), 64'd1);
        tick();
        drive(1, 1, 0, 0);
        check("latency_not_yet", 64'(id_valid), 64'd0);
        tick();
        for (int n = 0; n < 8; n++) begin
            drive(1, 1, 0, 0);
            check("stream_valid", 64'(id_valid), 64'd1);
            check("stream_pc", 64'(id_pc), 64'(n));
            check("stream_inst", 64'(id_inst), 64'(32'h1000_0000 + n));
            tick();
        end

        // Backpressure until full; head must hold.
        repeat (8) begin drive(1, 0, 0, 0); tick(); end
        drive(1, 1, 0, 0);
        check("full_stall", 64'(fetch_stall), 64'd1);
        check("full_no_issue", 64'(rom_ce), 64'd0);
        tick();
        drive(1, 0, 0, 0);
        check("after_pop_stall", 64'(fetch_stall), 64'd0);
        tick();

        // Flush with three entries queued and one read in flight.
        drive(1, 0, 1, 0);
        check("flush_rom_ce", 64'(rom_ce), 64'd0);
        tick();
        flush_pc = pc_r;
        drive(1, 1, 0, 0);
        check("post_flush_valid", 64'(id_valid), 64'd0);
        tick();
        drive(1, 1, 0, 0);
        check("post_flush_gap", 64'(id_valid), 64'd0);
        tick();
        drive(1, 1, 0, 0);
        check("post_flush_first", 64'(id_pc), 64'(flush_pc));
        tick();

        // Address wrap 62, 63, 0, 1.
        drive(0, 1, 1, 0); tick();
        pc_r = 6'd62;
        drive(1, 1, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        for (int n = 0; n < 4; n++) begin
            logic [ADDR_W-1:0] w;
            w = ADDR_W'(62 + n);
            drive(1, 1, 0, 0);
            check("wrap_pc", 64'(id_pc), 64'(w));
            check("wrap_inst", 64'(id_inst), 64'(rom_word(w)));
            tick();
        end

        // Reset while the queue is full and decode is ready.
        repeat (6) begin drive(1, 0, 0, 0); tick(); end
        drive(1, 1, 0, 1); tick();
        pc_r = '0;
        drive(0, 1, 0, 0);
        check("midrst_valid", 64'(id_valid), 64'd0);
        check("midrst_pc", 64'(id_pc), 64'd0);
        check("midrst_inst", 64'(id_inst), 64'd0);
        check("midrst_stall", 64'(fetch_stall), 64'd0);
        tick();
        drive(0, 1, 0, 0);
        check("midrst_no_stale", 64'(id_valid), 64'd0);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic c, r, f, s;
            c = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 99) < 5);
            s = ($urandom_range(0, 99) < 2);
            drive(c, r, f, s);
            tick();
            if (s) pc_r = ADDR_W'($urandom_range(0, 63));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction-fetch stage directly downstream of the program counter register. It turns each enabled `pc` into a synchronous instruction-ROM read, captures the returned word with its address, and buffers up to `DEPTH` fetched instructions for the decode stage behind a valid/ready handshake. When the buffer cannot accept more in-flight reads, it asserts a stall back to the PC stage so that no instruction is lost.

## Interface
- `ADDR_W`, 6, width of `pc` and of the ROM address.
- `DATA_W`, 32, instruction width.
- `DEPTH`, 4, queue entries; power of two, at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pc`  in  ADDR_W  fetch address from the PC stage.
- `ce`  in  1  fetch enable from the PC stage; 0 means the PC stage is in its reset state.
- `fetch_stall`  out  1  hold request to the PC stage; `pc` must be held while this is 1.
- `rom_ce`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM read address.
- `rom_data`  in  DATA_W  ROM read data, valid exactly 1 cycle after `rom_ce`=1.
- `flush`  in  1  discard all queued and in-flight instructions.
- `id_valid`  out  1  queue head is valid.
- `id_ready`  in  1  decode accepts the head this cycle.
- `id_pc`  out  ADDR_W  address of the head instruction.
- `id_inst`  out  DATA_W  head instruction word.

## Operation
- State:
  - circular buffer of `DEPTH` entries of {pc, inst};
  - read and write pointers, each log2(DEPTH) bits and wrapping modulo `DEPTH`;
  - `count`, 0..DEPTH;
  - `inflight` bit and `inflight_pc` register.
- `fetch_stall` is combinational: (`count` + `inflight`) >= `DEPTH`. The term uses registered values only. A pop in the current cycle does not relieve the stall; this is deliberately conservative.
- Issue: `rom_ce` = `ce` & !`fetch_stall` & !`flush`. `rom_addr` = `pc` at all times. On an issue, `inflight` <= 1 and `inflight_pc` <= `pc`; otherwise `inflight` <= 0.
- Return: when `inflight`=1 and `flush`=0, write {`inflight_pc`, `rom_data`} at the write pointer and advance the pointer.
- Pop: when `id_valid` & `id_ready`, advance the read pointer.
- `count` update: +1 on a push only, -1 on a pop only, unchanged on a simultaneous push and pop. A push into a full queue cannot occur, because the stall rule guarantees it.
- Head outputs: `id_valid` = (`count` != 0). `id_pc` and `id_inst` show the entry at the read pointer, forced to 0 when `count`=0.
- Flush, with priority over push, pop and issue: `count`, both pointers and `inflight` are cleared. ROM data returning in the cycle after the flush is discarded, and `rom_ce`=0 in the flush cycle.
- `pc` is carried unchanged. The 2^ADDR_W-1 -> 0 address wrap needs no special handling.
- `ce`=0 issues nothing. The queue keeps draining to decode while `ce`=0.

## Timing
- Reset (`rst`=1 at an edge) clears `count`, pointers, `inflight` and `inflight_pc`. After that edge, `id_valid`=0, `id_pc`=0, `id_inst`=0, `fetch_stall`=0, and `rom_ce`=`ce` (combinational).
- Reset also overrides `flush`, push and pop in the same cycle. Reset mid-stream drops every entry.
- Latency: an issue at cycle t puts data on `rom_data` at t+1, the entry is written at the end of t+1, and it appears on `id_*` with `id_valid`=1 at t+2 when the queue was empty.
- Throughput: 1 instruction per cycle sustained with `id_ready`=1, since steady state is `count`<=1 and `inflight`=1.
- The `id_*` outputs must be stable while `id_valid`=1 and `id_ready`=0.
- Flush at cycle t: `id_valid`=0 from t+1. The first post-flush issue can occur at t+1, and its data becomes visible at t+3.
- `rom_ce` is combinational from `ce`, `flush` and registered state. There is no combinational path from `id_ready` to `fetch_stall`.

## Test plan
- Reset/stream: hold `rst`=1 for 2 cycles, then `ce`=1 with `pc` counting 0,1,2…, ROM word = 0x1000_0000+addr, `id_ready`=1. Required: first `id_valid` 2 cycles after the first issue, then (`id_pc`,`id_inst`) = (0,0x10000000),(1,0x10000001)… with no gaps.
- Backpressure: `id_ready`=0 while streaming. Required: `fetch_stall`=1 once `count`+`inflight` reaches 4, `count` saturates at exactly 4, and the head stays at pc 0. Release `id_ready`: pcs 0..N arrive in order with none lost or duplicated.
- Full with simultaneous pop: at `count`=4, drive `id_ready`=1 for 1 cycle. Required: `count`=3, `fetch_stall` stays 1 in the pop cycle and drops to 0 the next cycle.
- Flush: assert `flush` for 1 cycle with 3 entries queued and `inflight`=1. Required: `id_valid`=0 the next cycle, the returning word is dropped, and the next `pc` issued appears first.
- Address wrap: stream `pc` 62,63,0,1. Required: `id_pc` 62,63,0,1 with the matching ROM words.
- Reset mid-operation: `rst`=1 with the queue full and `id_ready`=1. Required: all outputs reset next cycle, nothing popped, and stale in-flight data is never presented.
